uart_rx_fifo_ctrl: RTL and testbench
====================================

# uart_rx_fifo_ctrl

Single-clock controller that owns the UART receive byte FIFO and sequences access to it. Accepts bytes from the UART receiver on the write side and serves CPU load requests on the read side. Each CPU read returns one byte, or four bytes packed into a 32-bit word. Sits between the UART RX shifter and the processor's memory-mapped UART data/status registers, and adds overflow tracking, flush, and a multi-cycle read FSM.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥4
- AW, 4, pointer width = log2(DEPTH)
- UART_CLK  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- cpu_rd_req  in  1  one-cycle read request; sampled only in IDLE
- cpu_rd_word  in  1  sampled with cpu_rd_req; 1 = pack 4 bytes, 0 = single byte
- cpu_rd_data  out  32  read result; valid only while cpu_rd_valid
- cpu_rd_valid  out  1  one-cycle completion strobe
- cpu_rd_err  out  1  qualifies cpu_rd_valid; 1 = insufficient data or flushed
- busy  out  1  FSM not in IDLE
- flush  in  1  one-cycle strobe: empty the FIFO, abort any read
- clr_ovf  in  1  clear the sticky overflow flag
- count  out  AW+1  bytes stored, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a byte was dropped

## Operation
- **Write side.** rx_valid & !full stores rx_data at wptr, then wptr+1 (wraps mod DEPTH).
  - rx_valid & full: byte dropped, overflow set.
  - full is taken from the registered count. A push in the same cycle as a pop while full is still refused and sets overflow.
- **Count.** Push only: +1. Pop only: −1. Push and pop together: unchanged.
- **FSM states:** IDLE, POP, DONE.
  - IDLE, cpu_rd_req, need = cpu_rd_word ? 4 : 1.
    - count ≥ need: go to POP, set nleft = need.
    - count < need: go to DONE with err=1, data=0. Nothing is popped.
  - POP, one byte per cycle:
    - Latch mem[rptr] into byte lane (need − nleft), then rptr+1 and nleft−1.
    - Exit to DONE when nleft reaches 1 in this cycle.
    - Lanes are little-endian: the first byte popped goes to [7:0].
  - DONE: assert cpu_rd_valid for one cycle, then return to IDLE.
    - Byte mode: cpu_rd_data = {24'h0, byte}.
- cpu_rd_req outside IDLE is ignored. The CPU must not re-request until it sees cpu_rd_valid.
- **Flush.** Highest priority.
  - wptr, rptr and count go to 0, and any same-cycle push/pop is discarded.
  - In POP: go to DONE with err=1 and data=0. Bytes already popped are lost.
  - In IDLE or DONE: state unaffected.
  - overflow is not cleared by flush.
- clr_ovf clears overflow. If an overflow event occurs in the same cycle, set wins.
- Storage is not reset. Data reads are of written locations only.

## Timing
- **Reset (async assert, sync deassert expected).**
  - State IDLE; wptr, rptr and count are 0.
  - cpu_rd_data=0, cpu_rd_valid=0, cpu_rd_err=0, busy=0, overflow=0.
  - empty=1, full=0.
- **Write.** A byte pushed at edge N is visible in count/empty after edge N. It is poppable by a request sampled at edge N+1.
- **Byte read.** Request at edge N; POP during cycle N+1; cpu_rd_valid after edge N+2. Latency 2.
- **Word read.** POP during cycles N+1..N+4; cpu_rd_valid after edge N+5. Latency 5.
- **Insufficient data.** cpu_rd_valid with err after edge N+1.
- busy is high from the edge after the request up to and including the DONE cycle.
- **Outputs.** cpu_rd_data and cpu_rd_valid/err are registered. count, empty and full are registered. No combinational path from inputs to outputs.
- **Reset mid-operation.** Immediate return to reset values. A pending read never completes.

## Structure
- Shared header uart_defs.vh holds:
  - FSM state encodings S_IDLE, S_POP, S_DONE
  - default DEPTH/AW
  - RD_BYTE/RD_WORD constants
- Sub-module uart_fifo_mem: DEPTH×8 array with synchronous write (we, waddr, wdata) and asynchronous read (raddr → rdata), no reset.
- The controller holds pointers, count, overflow, FSM, nleft and the packing register.

## Test plan
- Reset, push 0x41, byte read → cpu_rd_valid two cycles after the request. data=0x00000041, err=0, count 1→0, empty=1.
- Push 0x11,0x22,0x33,0x44, word read → valid five cycles after the request. data=0x44332211, err=0, busy high for 5 cycles.
- Push 17 bytes 0x00..0x10 → full=1 after 16. Overflow set on the 17th. Read 16 bytes: 0x00..0x0F in order, with the pointers wrapping correctly. clr_ovf → overflow=0.
- Push 3 bytes, word read → valid one cycle after the request with err=1, data=0. count stays 3.
- Push 8 bytes, word read, flush during the second POP cycle → valid with err=1, data=0. count=0, empty=1, and subsequent push/read behave normally.
- Full FIFO with push and byte read in the same cycle → push refused and overflow=1. count goes 16→15 and the read returns the oldest byte.

Source files
------------

// File: rtl/uart_rx_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_ctrl_pkg
// Purpose  : Shared FSM encodings, default sizes and read-mode constants.
// Revision : 1.0
// ============================================================================
package uart_rx_fifo_ctrl_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int AW_DEF    = 4;

    localparam logic RD_BYTE = 1'b0;
    localparam logic RD_WORD = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic [2:0] need_bytes(input logic word);
        return (word == RD_WORD) ? 3'd4 : 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_ctrl_if
// Purpose  : UART RX side, CPU read side and status bundle of the RX FIFO.
// Revision : 1.0
// ============================================================================
interface uart_rx_fifo_ctrl_if
    import uart_rx_fifo_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF
);
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          cpu_rd_req;
    logic          cpu_rd_word;
    logic [31:0]   cpu_rd_data;
    logic          cpu_rd_valid;
    logic          cpu_rd_err;
    logic          busy;
    logic          flush;
    logic          clr_ovf;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;

    modport slave (
        input  rx_valid, rx_data, cpu_rd_req, cpu_rd_word, flush, clr_ovf,
        output cpu_rd_data, cpu_rd_valid, cpu_rd_err, busy,
               count, empty, full, overflow
    );

    modport master (
        output rx_valid, rx_data, cpu_rd_req, cpu_rd_word, flush, clr_ovf,
        input  cpu_rd_data, cpu_rd_valid, cpu_rd_err, busy,
               count, empty, full, overflow
    );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_mem
// Purpose  : DEPTH x 8 storage, synchronous write, asynchronous read, no reset.
// Revision : 1.0
// ============================================================================
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_ctrl
// Purpose  : UART RX byte FIFO with overflow/flush and a byte/word read FSM.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo_ctrl
    import uart_rx_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                 UART_CLK,
    input  logic                 reset_n,
    uart_rx_fifo_ctrl_if.slave   bus
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [2:0]    nleft_q, nleft_d;
    logic          word_q, word_d;
    logic          err_q, err_d;
    logic [31:0]   pack_q, pack_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_err_q, rd_err_d;

    logic          full_w, push_w, pop_w;
    logic [7:0]    rdata_w;
    logic [1:0]    lane_w;
    logic [2:0]    need_w;

    // full comes from the registered count, so a pop never frees room for a same-cycle push
    assign full_w = (count_q == DEPTH_C);
    assign push_w = bus.rx_valid && !full_w;
    assign pop_w  = (state_q == S_POP);
    assign lane_w = word_q ? 2'(3'd4 - nleft_q) : 2'd0;
    assign need_w = need_bytes(bus.cpu_rd_word);

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (UART_CLK),
        .we    (push_w && !bus.flush),
        .waddr (wptr_q),
        .wdata (bus.rx_data),
        .raddr (rptr_q),
        .rdata (rdata_w)
    );

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (bus.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_w) wptr_d = wptr_q + AW'(1);
            if (pop_w)  rptr_d = rptr_q + AW'(1);
            if (push_w && !pop_w)      count_d = count_q + (AW+1)'(1);
            else if (!push_w && pop_w) count_d = count_q - (AW+1)'(1);
        end
        ovf_d = (bus.rx_valid && full_w) ? 1'b1 : (bus.clr_ovf ? 1'b0 : ovf_q);
    end

    always_comb begin
        state_d    = state_q;
        nleft_d    = nleft_q;
        word_d     = word_q;
        err_d      = err_q;
        pack_d     = pack_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_rd_req) begin
                    word_d  = bus.cpu_rd_word;
                    nleft_d = need_w;
                    pack_d  = '0;
                    // A request coinciding with flush sees an empty FIFO
                    if (bus.flush || (count_q < (AW+1)'(need_w))) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_POP;
                        err_d   = 1'b0;
                    end
                end
            end
            S_POP: begin
                if (bus.flush) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    pack_d[{lane_w, 3'b000} +: 8] = rdata_w;
                    nleft_d = nleft_q - 3'd1;
                    if (nleft_q == 3'd1) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                rd_valid_d = 1'b1;
                rd_err_d   = err_q;
                rd_data_d  = err_q ? 32'h0 : pack_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge UART_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            nleft_q    <= '0;
            word_q     <= 1'b0;
            err_q      <= 1'b0;
            pack_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            nleft_q    <= nleft_d;
            word_q     <= word_d;
            err_q      <= err_d;
            pack_q     <= pack_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign bus.cpu_rd_data  = rd_data_q;
    assign bus.cpu_rd_valid = rd_valid_q;
    assign bus.cpu_rd_err   = rd_err_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.count        = count_q;
    assign bus.empty        = (count_q == '0);
    assign bus.full         = full_w;
    assign bus.overflow     = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo_ctrl
// Purpose  : Table-driven and scoreboard self-checking bench for the RX FIFO.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_fifo_ctrl;
    import uart_rx_fifo_ctrl_pkg::*;

    localparam int OP_PUSH = 0;
    localparam int OP_RDB  = 1;
    localparam int OP_RDW  = 2;
    localparam int OP_CLR  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_rx_fifo_ctrl_if #(.AW(4)) bus();

    uart_rx_fifo_ctrl #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .UART_CLK (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        int          op;
        logic [7:0]  din;
        logic [4:0]  exp_count;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_ovf;
    } vec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] mq[$];
    exp_t       sb[$];
    vec_t       vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [4:0] c, input logic e,
                                input logic f, input logic o);
        check({tag, " count"},    32'(bus.count),    32'(c));
        check({tag, " empty"},    32'(bus.empty),    32'(e));
        check({tag, " full"},     32'(bus.full),     32'(f));
        check({tag, " overflow"}, 32'(bus.overflow), 32'(o));
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        if (mq.size() < 16) mq.push_back(b);
    endtask

    // Called #1 after the request edge; lat0 accounts for cycles already spent
    task automatic wait_result(input string tag, input int lat0);
        int   lat = lat0;
        int   busy_cnt = lat0;
        exp_t e;
        while (!bus.cpu_rd_valid && lat < 12) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.cpu_rd_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: no cpu_rd_valid after %0d cycles", tag, lat);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check({tag, " data"},    bus.cpu_rd_data,     e.data);
        check({tag, " err"},     32'(bus.cpu_rd_err), 32'(e.err));
        check({tag, " latency"}, 32'(lat),            32'(e.lat));
        check({tag, " busy"},    32'(busy_cnt),       32'(e.lat));
        @(posedge clk); #1;
        check({tag, " one-shot"}, 32'(bus.cpu_rd_valid), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic word);
        exp_t e;
        int   need = word ? 4 : 1;
        e.data = 32'h0;
        if (mq.size() < need) begin
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            for (int i = 0; i < need; i++) e.data[8*i +: 8] = mq.pop_front();
            e.err = 1'b0;
            e.lat = need + 1;
        end
        sb.push_back(e);
        bus.cpu_rd_word = word;
        bus.cpu_rd_req  = 1'b1;
        @(posedge clk); #1;
        bus.cpu_rd_req  = 1'b0;
        bus.cpu_rd_word = 1'b0;
        wait_result(tag, 0);
    endtask

    initial begin
        int   seen;
        exp_t e;

        // Stimulus table: inputs with the status expected after each step
        vecs.push_back('{OP_PUSH, 8'h41, 5'd1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_RDB,  8'h00, 5'd0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{OP_PUSH, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_PUSH, 8'h22, 5'd2, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_PUSH, 8'h33, 5'd3, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_PUSH, 8'h44, 5'd4, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_RDW,  8'h00, 5'd0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{OP_PUSH, 8'hAA, 5'd1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_PUSH, 8'hBB, 5'd2, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_PUSH, 8'hCC, 5'd3, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_RDW,  8'h00, 5'd3, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_RDB,  8'h00, 5'd2, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_RDB,  8'h00, 5'd1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_RDB,  8'h00, 5'd0, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 17; i++)
            vecs.push_back('{OP_PUSH, 8'(i), 5'((i < 16) ? i + 1 : 16), 1'b0,
                             (i >= 15), (i == 16)});
        for (int i = 0; i < 16; i++)
            vecs.push_back('{OP_RDB, 8'h00, 5'(15 - i), (i == 15), 1'b0, 1'b1});
        vecs.push_back('{OP_CLR,  8'h00, 5'd0, 1'b1, 1'b0, 1'b0});

        rst_n           = 1'b0;
        bus.rx_valid    = 1'b0;
        bus.rx_data     = 8'h00;
        bus.cpu_rd_req  = 1'b0;
        bus.cpu_rd_word = 1'b0;
        bus.flush       = 1'b0;
        bus.clr_ovf     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 5'd0, 1'b1, 1'b0, 1'b0);
        check("reset valid", 32'(bus.cpu_rd_valid), 32'd0);
        check("reset err",   32'(bus.cpu_rd_err),   32'd0);
        check("reset busy",  32'(bus.busy),         32'd0);
        check("reset data",  bus.cpu_rd_data,       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < vecs.size(); v++) begin
            string tag = $sformatf("vec%0d", v);
            case (vecs[v].op)
                OP_PUSH: push_byte(vecs[v].din);
                OP_RDB:  do_read(tag, RD_BYTE);
                OP_RDW:  do_read(tag, RD_WORD);
                default: begin
                    bus.clr_ovf = 1'b1;
                    @(posedge clk); #1;
                    bus.clr_ovf = 1'b0;
                end
            endcase
            check_status(tag, vecs[v].exp_count, vecs[v].exp_empty,
                         vecs[v].exp_full, vecs[v].exp_ovf);
        end

        // Flush during the second POP cycle of a word read
        for (int i = 0; i < 8; i++) push_byte(8'(8'h60 + i));
        check_status("flush pre", 5'd8, 1'b0, 1'b0, 1'b0);
        bus.cpu_rd_word = 1'b1;
        bus.cpu_rd_req  = 1'b1;
        @(posedge clk); #1;
        bus.cpu_rd_req  = 1'b0;
        bus.cpu_rd_word = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        mq.delete();
        check("flush done busy",  32'(bus.busy),         32'd1);
        check("flush early valid", 32'(bus.cpu_rd_valid), 32'd0);
        sb.push_back('{32'h0, 1'b1, 3});
        wait_result("flush rd", 2);
        check_status("flush post", 5'd0, 1'b1, 1'b0, 1'b0);
        push_byte(8'h5A);
        check_status("flush push", 5'd1, 1'b0, 1'b0, 1'b0);
        do_read("flush after", RD_BYTE);

        // Full FIFO: push in the same edge as a pop is refused
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
        check_status("full pre", 5'd16, 1'b0, 1'b1, 1'b0);
        e.data = {24'h0, mq.pop_front()};
        e.err  = 1'b0;
        e.lat  = 2;
        sb.push_back(e);
        bus.cpu_rd_req = 1'b1;
        @(posedge clk); #1;
        bus.cpu_rd_req = 1'b0;
        bus.rx_data    = 8'hEE;
        bus.rx_valid   = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid   = 1'b0;
        check_status("full pushpop", 5'd15, 1'b0, 1'b0, 1'b1);
        wait_result("full rd", 1);
        do_read("full next", RD_BYTE);

        // Reset in the middle of a word read: no completion afterwards
        bus.cpu_rd_word = 1'b1;
        bus.cpu_rd_req  = 1'b1;
        @(posedge clk); #1;
        bus.cpu_rd_req  = 1'b0;
        bus.cpu_rd_word = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_status("midrst", 5'd0, 1'b1, 1'b0, 1'b0);
        check("midrst busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mq.delete();
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.cpu_rd_valid) seen++;
        end
        check("midrst no valid", 32'(seen), 32'd0);
        push_byte(8'h7E);
        do_read("midrst after", RD_BYTE);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
